cnfg_reg_bank: RTL and testbench



---
 rtl/cnfg_reg_bank_pkg.sv | 21 ++
 rtl/cmd_fifo.sv | 53 +++++
 rtl/cnfg_reg_bank.sv | 151 +++++++++++++++
 tb/tb_cnfg_reg_bank.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnfg_reg_bank_pkg.sv
// rtl/cnfg_reg_bank_pkg.sv - shared address offsets and STATUS field layout for cnfg_reg_bank
package cnfg_reg_bank_pkg;

  // Offsets above the range-register block (base address NUM_RANGES)
  localparam int unsigned OFS_MISC      = 0;
  localparam int unsigned OFS_ADDR      = 1;
  localparam int unsigned OFS_CMD       = 2;
  localparam int unsigned OFS_STATUS    = 3;
  localparam int unsigned OFS_SNAP_FSM  = 4;
  localparam int unsigned OFS_SNAP_DIAG = 5;

  // STATUS flags sit directly above the count field, LSB first
  localparam int unsigned ST_EMPTY_REL = 0;
  localparam int unsigned ST_FULL_REL  = 1;
  localparam int unsigned ST_OVF_REL   = 2;

  function automatic int unsigned st_bit(input int unsigned cnt_w, input int unsigned rel);
    return cnt_w + rel;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - command FIFO; a push into a full FIFO lands only when a pop frees a slot the same cycle
module cmd_fifo #(
  parameter int CMD_W     = 8,
  parameter int CMD_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [CMD_W-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(CMD_DEPTH):0]   count_o,
  output logic [CMD_W-1:0]             head_o
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(CMD_DEPTH);

  logic [CMD_W-1:0] mem_q [CMD_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_eff, push_eff;

  always_comb begin
    pop_eff  = pop_i && (count_q != '0);
    push_eff = push_i && ((count_q != DEPTH_C) || pop_eff);
    wr_ptr_d = wr_ptr_q + PW'(push_eff);
    rd_ptr_d = rd_ptr_q + PW'(pop_eff);
    count_d  = count_q + CW'(push_eff) - CW'(pop_eff);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_eff) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/cnfg_reg_bank.sv
// rtl/cnfg_reg_bank.sv - APB-style configuration bank: range/misc/addr registers, command FIFO, snapshots
module cnfg_reg_bank
  import cnfg_reg_bank_pkg::*;
#(
  parameter int                NUM_RANGES = 8,
  parameter int                DATA_W     = 160,
  parameter int                ADDR_W     = 5,
  parameter int                CMD_W      = 8,
  parameter int                CMD_DEPTH  = 4,
  parameter logic [DATA_W-1:0] ID_DATA    = DATA_W'('h52414D)
) (
  input  logic                          sclk,
  input  logic                          rst,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [ADDR_W-1:0]             paddr,
  input  logic [DATA_W-1:0]             pwdata,
  output logic [DATA_W-1:0]             prdata,
  input  logic [$clog2(NUM_RANGES)-1:0] rangei,
  output logic [DATA_W-1:0]             prog_cnfg,
  output logic [DATA_W-1:0]             misc_cnfg,
  output logic [DATA_W-1:0]             addr_cnfg,
  output logic                          cmd_valid,
  output logic [CMD_W-1:0]              cmd_data,
  input  logic                          cmd_ready,
  input  logic [DATA_W-1:0]             fsm_bits,
  input  logic [DATA_W-1:0]             diag_bits
);

  localparam int RW = $clog2(NUM_RANGES);
  localparam int CW = $clog2(CMD_DEPTH) + 1;

  localparam logic [ADDR_W-1:0] A_MISC      = ADDR_W'(NUM_RANGES + OFS_MISC);
  localparam logic [ADDR_W-1:0] A_ADDR      = ADDR_W'(NUM_RANGES + OFS_ADDR);
  localparam logic [ADDR_W-1:0] A_CMD       = ADDR_W'(NUM_RANGES + OFS_CMD);
  localparam logic [ADDR_W-1:0] A_STATUS    = ADDR_W'(NUM_RANGES + OFS_STATUS);
  localparam logic [ADDR_W-1:0] A_SNAP_FSM  = ADDR_W'(NUM_RANGES + OFS_SNAP_FSM);
  localparam logic [ADDR_W-1:0] A_SNAP_DIAG = ADDR_W'(NUM_RANGES + OFS_SNAP_DIAG);
  localparam logic [ADDR_W-1:0] A_ID        = '1;

  logic [DATA_W-1:0] range_q [NUM_RANGES];
  logic [DATA_W-1:0] range_d [NUM_RANGES];
  logic [DATA_W-1:0] misc_q, misc_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] snap_fsm_q, snap_fsm_d;
  logic [DATA_W-1:0] snap_diag_q, snap_diag_d;
  logic              ovf_q, ovf_d;

  logic              wr, rd, push, pop;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CMD_W-1:0]  fifo_head;
  logic [DATA_W-1:0] status_word;

  assign wr   = psel && penable && pwrite;
  assign rd   = psel && penable && !pwrite;
  assign push = wr && (paddr == A_CMD);
  assign pop  = cmd_valid && cmd_ready;

  cmd_fifo #(
    .CMD_W     (CMD_W),
    .CMD_DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i       (sclk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (pwdata[CMD_W-1:0]),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  always_comb begin
    range_d     = range_q;
    misc_d      = misc_q;
    addr_d      = addr_q;
    snap_fsm_d  = snap_fsm_q;
    snap_diag_d = snap_diag_q;
    if (wr) begin
      if (paddr < A_MISC)            range_d[paddr[RW-1:0]] = pwdata;
      else if (paddr == A_MISC)      misc_d = pwdata;
      else if (paddr == A_ADDR)      addr_d = pwdata;
      else if (paddr == A_SNAP_FSM) begin
        snap_fsm_d  = fsm_bits;
        snap_diag_d = diag_bits;
      end
    end
    // A fresh overflow beats the read-to-clear in the same cycle
    ovf_d = ovf_q;
    if (rd && (paddr == A_STATUS)) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RANGES; i++) range_q[i] <= '0;
      misc_q      <= '0;
      addr_q      <= '0;
      snap_fsm_q  <= '0;
      snap_diag_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      range_q     <= range_d;
      misc_q      <= misc_d;
      addr_q      <= addr_d;
      snap_fsm_q  <= snap_fsm_d;
      snap_diag_q <= snap_diag_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    status_word = '0;
    status_word[CW-1:0] = fifo_count;
    status_word[st_bit(CW, ST_EMPTY_REL)] = fifo_empty;
    status_word[st_bit(CW, ST_FULL_REL)]  = fifo_full;
    status_word[st_bit(CW, ST_OVF_REL)]   = ovf_q;
  end

  always_comb begin
    prdata = '0;
    if (paddr < A_MISC) begin
      prdata = range_q[paddr[RW-1:0]];
    end else begin
      case (paddr)
        A_MISC:      prdata = misc_q;
        A_ADDR:      prdata = addr_q;
        A_CMD:       prdata[CMD_W-1:0] = fifo_head;
        A_STATUS:    prdata = status_word;
        A_SNAP_FSM:  prdata = snap_fsm_q;
        A_SNAP_DIAG: prdata = snap_diag_q;
        A_ID:        prdata = ID_DATA;
        default:     prdata = '0;
      endcase
    end
  end

  always_comb begin
    prog_cnfg = '0;
    if (32'(rangei) < 32'(NUM_RANGES)) prog_cnfg = range_q[rangei];
  end

  assign misc_cnfg = misc_q;
  assign addr_cnfg = addr_q;
  assign cmd_valid = !fifo_empty;
  assign cmd_data  = fifo_head;

endmodule

// File: tb/tb_cnfg_reg_bank.sv
// tb/tb_cnfg_reg_bank.sv - directed self-checking bench for cnfg_reg_bank (default parameters)
module tb_cnfg_reg_bank;

  logic         sclk = 1'b0;
  logic         rst = 1'b1;
  logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0]   paddr = '0;
  logic [159:0] pwdata = '0;
  logic [159:0] prdata;
  logic [2:0]   rangei = '0;
  logic [159:0] prog_cnfg, misc_cnfg, addr_cnfg;
  logic         cmd_valid;
  logic [7:0]   cmd_data;
  logic         cmd_ready = 1'b0;
  logic [159:0] fsm_bits = '0, diag_bits = '0;

  int total = 0;
  int bad = 0;
  logic [159:0] rdata;

  // Default map: ranges 0..7, MISC 8, ADDR 9, CMD 10, STATUS 11, SNAP_FSM 12, SNAP_DIAG 13, ID 31
  // STATUS: count[2:0], empty bit3, full bit4, overflow bit5
  localparam logic [4:0] A_MISC = 5'd8, A_ADDR = 5'd9, A_CMD = 5'd10, A_STATUS = 5'd11;
  localparam logic [4:0] A_SNAPF = 5'd12, A_SNAPD = 5'd13, A_ID = 5'd31;
  localparam logic [159:0] ST_EMPTY = 160'h08, ST_FULL = 160'h14, ST_FULL_OVF = 160'h34;
  localparam logic [159:0] ID_EXP = 160'h52414D;

  cnfg_reg_bank dut (
    .sclk      (sclk),
    .rst       (rst),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .rangei    (rangei),
    .prog_cnfg (prog_cnfg),
    .misc_cnfg (misc_cnfg),
    .addr_cnfg (addr_cnfg),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .fsm_bits  (fsm_bits),
    .diag_bits (diag_bits)
  );

  always #5 sclk = ~sclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic do_write(input logic [4:0] a, input logic [159:0] d);
    @(negedge sclk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge sclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a);
    @(negedge sclk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
    #1 rdata = prdata;
    @(negedge sclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge sclk);
    rst = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid: got %0h want 0", cmd_valid); end
    total++; if (cmd_data !== 8'h00) begin bad++; $display("FAIL reset_cmd_data: got %0h want 0", cmd_data); end
    total++; if (misc_cnfg !== '0) begin bad++; $display("FAIL reset_misc: got %0h want 0", misc_cnfg); end
    do_read(A_STATUS);
    total++; if (rdata !== ST_EMPTY) begin bad++; $display("FAIL reset_status: got %0h want %0h", rdata, ST_EMPTY); end
    do_read(A_ID);
    total++; if (rdata !== ID_EXP) begin bad++; $display("FAIL reset_id: got %0h want %0h", rdata, ID_EXP); end
  endtask

  task automatic test_regs();
    rangei = 3'd3;
    do_write(5'd3, 160'hA5);
    #1;
    total++; if (prog_cnfg !== 160'hA5) begin bad++; $display("FAIL range3_prog: got %0h want a5", prog_cnfg); end
    do_read(5'd3);
    total++; if (rdata !== 160'hA5) begin bad++; $display("FAIL range3_read: got %0h want a5", rdata); end
    do_write(5'd0, 160'h1111);
    do_write(5'd7, {32'hDEADBEEF, 128'h7777});
    do_read(5'd0);
    total++; if (rdata !== 160'h1111) begin bad++; $display("FAIL range0_read: got %0h want 1111", rdata); end
    rangei = 3'd7;
    #1;
    total++; if (prog_cnfg !== {32'hDEADBEEF, 128'h7777}) begin bad++; $display("FAIL range7_prog: got %0h want deadbeef..7777", prog_cnfg); end
    rangei = 3'd3;
    do_write(A_MISC, 160'hC0FFEE);
    do_write(A_ADDR, 160'h00400010_0001);
    #1;
    total++; if (misc_cnfg !== 160'hC0FFEE) begin bad++; $display("FAIL misc_out: got %0h want c0ffee", misc_cnfg); end
    total++; if (addr_cnfg !== 160'h00400010_0001) begin bad++; $display("FAIL addr_out: got %0h want 4000100001", addr_cnfg); end
    do_read(A_ADDR);
    total++; if (rdata !== 160'h00400010_0001) begin bad++; $display("FAIL addr_read: got %0h want 4000100001", rdata); end
    do_write(5'd14, 160'h99);
    do_read(5'd14);
    total++; if (rdata !== '0) begin bad++; $display("FAIL unmapped_read: got %0h want 0", rdata); end
    do_read(5'd3);
    total++; if (rdata !== 160'hA5) begin bad++; $display("FAIL range3_intact: got %0h want a5", rdata); end
  endtask

  task automatic test_fifo_overflow();
    cmd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) do_write(A_CMD, 160'(i));
    #1;
    total++; if (cmd_valid !== 1'b1 || cmd_data !== 8'd1) begin bad++; $display("FAIL ovf_head: got valid=%0h data=%0h want 1/1", cmd_valid, cmd_data); end
    do_read(A_CMD);
    total++; if (rdata !== 160'd1) begin bad++; $display("FAIL cmd_read: got %0h want 1", rdata); end
    do_read(A_STATUS);
    total++; if (rdata !== ST_FULL_OVF) begin bad++; $display("FAIL ovf_status: got %0h want %0h", rdata, ST_FULL_OVF); end
    @(negedge sclk);
    cmd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      total++; if (cmd_valid !== 1'b1 || cmd_data !== 8'(i)) begin bad++; $display("FAIL ovf_pop%0d: got valid=%0h data=%0h want 1/%0h", i, cmd_valid, cmd_data, i); end
      @(negedge sclk);
    end
    cmd_ready = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b0 || cmd_data !== 8'h00) begin bad++; $display("FAIL ovf_drained: got valid=%0h data=%0h want 0/0", cmd_valid, cmd_data); end
    do_read(A_STATUS);
    total++; if (rdata !== ST_EMPTY) begin bad++; $display("FAIL ovf_empty_status: got %0h want %0h", rdata, ST_EMPTY); end
  endtask

  task automatic test_full_push_pop();
    cmd_ready = 1'b0;
    for (int i = 5; i <= 8; i++) do_write(A_CMD, 160'(i));
    @(negedge sclk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = A_CMD; pwdata = 160'h9;
    cmd_ready = 1'b1;
    @(negedge sclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    cmd_ready = 1'b0;
    do_read(A_STATUS);
    total++; if (rdata !== ST_FULL) begin bad++; $display("FAIL pushpop_status: got %0h want %0h", rdata, ST_FULL); end
    @(negedge sclk);
    cmd_ready = 1'b1;
    for (int i = 6; i <= 9; i++) begin
      #1;
      total++; if (cmd_data !== 8'(i)) begin bad++; $display("FAIL pushpop_order%0d: got %0h want %0h", i, cmd_data, i); end
      @(negedge sclk);
    end
    cmd_ready = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL pushpop_drained: got %0h want 0", cmd_valid); end
  endtask

  task automatic test_empty_push_pop();
    @(negedge sclk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = A_CMD; pwdata = 160'h3C;
    cmd_ready = 1'b1;
    @(negedge sclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    cmd_ready = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b1 || cmd_data !== 8'h3C) begin bad++; $display("FAIL empty_pushpop: got valid=%0h data=%0h want 1/3c", cmd_valid, cmd_data); end
    do_read(A_STATUS);
    total++; if (rdata !== 160'h01) begin bad++; $display("FAIL empty_pushpop_status: got %0h want 1", rdata); end
    @(negedge sclk);
    cmd_ready = 1'b1;
    @(negedge sclk);
    cmd_ready = 1'b0;
  endtask

  task automatic test_ovf_clear();
    for (int i = 1; i <= 5; i++) do_write(A_CMD, 160'(8'h20 + i));
    do_read(A_STATUS);
    total++; if (rdata !== ST_FULL_OVF) begin bad++; $display("FAIL clr_first: got %0h want %0h", rdata, ST_FULL_OVF); end
    do_read(A_STATUS);
    total++; if (rdata !== ST_FULL) begin bad++; $display("FAIL clr_second: got %0h want %0h", rdata, ST_FULL); end
    do_write(A_CMD, 160'h66);
    do_read(A_STATUS);
    total++; if (rdata !== ST_FULL_OVF) begin bad++; $display("FAIL clr_reset_again: got %0h want %0h", rdata, ST_FULL_OVF); end
    #1;
    total++; if (cmd_data !== 8'h21) begin bad++; $display("FAIL clr_head: got %0h want 21", cmd_data); end
    @(negedge sclk);
    cmd_ready = 1'b1;
    repeat (4) @(negedge sclk);
    cmd_ready = 1'b0;
  endtask

  task automatic test_snapshot();
    fsm_bits = 160'h11;
    diag_bits = 160'h33;
    do_write(A_SNAPF, 160'hFF);
    fsm_bits = 160'h22;
    diag_bits = 160'h44;
    do_read(A_SNAPF);
    total++; if (rdata !== 160'h11) begin bad++; $display("FAIL snap_fsm: got %0h want 11", rdata); end
    do_read(A_SNAPD);
    total++; if (rdata !== 160'h33) begin bad++; $display("FAIL snap_diag: got %0h want 33", rdata); end
    do_write(A_SNAPD, 160'h77);
    do_read(A_SNAPD);
    total++; if (rdata !== 160'h33) begin bad++; $display("FAIL snap_diag_ro: got %0h want 33", rdata); end
  endtask

  task automatic test_reset_mid();
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_write(A_CMD, 160'(8'h40 + i));
    do_read(A_STATUS);
    total++; if (rdata !== 160'h03) begin bad++; $display("FAIL mid_pre_status: got %0h want 3", rdata); end
    @(negedge sclk);
    rst = 1'b1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = A_MISC; pwdata = 160'hBEEF;
    @(negedge sclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rst = 1'b0;
    rangei = 3'd3;
    #1;
    total++; if (cmd_valid !== 1'b0 || cmd_data !== 8'h00) begin bad++; $display("FAIL mid_cmd: got valid=%0h data=%0h want 0/0", cmd_valid, cmd_data); end
    total++; if (misc_cnfg !== '0 || addr_cnfg !== '0) begin bad++; $display("FAIL mid_regs: got misc=%0h addr=%0h want 0/0", misc_cnfg, addr_cnfg); end
    total++; if (prog_cnfg !== '0) begin bad++; $display("FAIL mid_prog: got %0h want 0", prog_cnfg); end
    do_read(A_SNAPF);
    total++; if (rdata !== '0) begin bad++; $display("FAIL mid_snap: got %0h want 0", rdata); end
    do_read(A_STATUS);
    total++; if (rdata !== ST_EMPTY) begin bad++; $display("FAIL mid_status: got %0h want %0h", rdata, ST_EMPTY); end
    do_read(A_ID);
    total++; if (rdata !== ID_EXP) begin bad++; $display("FAIL mid_id: got %0h want %0h", rdata, ID_EXP); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_fifo_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_ovf_clear();
    test_snapshot();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
